// File: rtl/mfrc522_spi_pkg.sv
// Shared constants and helpers for the MFRC522 SPI sequencer.
package mfrc522_spi_pkg;

  localparam int unsigned MAX_LEN_DEF = 16;
  localparam int unsigned READ_FLAG   = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // MFRC522 address byte: {rd_nwr, addr[5:0], 0}
  function automatic logic [7:0] fmt_addr_byte(input logic rd_nwr, input logic [5:0] addr);
    logic [7:0] b;
    b            = {1'b0, addr, 1'b0};
    b[READ_FLAG] = rd_nwr;
    return b;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period tick counter and mode-0 SCLK toggle; held cleared while the
// sequencer is outside a frame.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned CNT_W  = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             toggle_en_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sclk_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sclk_q, sclk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sclk_q <= sclk_d;
    end
  end

  // tick is registered one cycle ahead so it is high while cnt is at its last value
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else begin
      cnt_d  = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(CLK_DIV - 2));
      if (tick_q && toggle_en_i) sclk_d = ~sclk_q;
    end
  end

  assign tick_o = tick_q;
  assign cnt_o  = cnt_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/mfrc522_spi_ctrl.sv
// SPI transaction sequencer for the MFRC522: frames address + burst data bytes.
// Define SPI_LOOPBACK_EN to capture the driven mosi instead of the miso pin.
module mfrc522_spi_ctrl
  import mfrc522_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             rd_nwr_i,
  input  logic [5:0]       addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             wr_req_o,
  input  logic [7:0]       wr_data_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sclk_o,
  output logic             cs_n_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned WREQ_AT = 16 * CLK_DIV - 3;

  logic [2:0]       state_q, state_d;
  logic             rd_q, rd_d;
  logic [5:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [3:0]       hp_q, hp_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       wbuf_q, wbuf_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_req_q, wr_req_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             sclk_w;
  logic             in_frame_c;
  logic             miso_s;
  logic [7:0]       abyte_c;
  logic [7:0]       next_byte_c;
  logic [LEN_W-1:0] len_clamp_c;
  int unsigned      pos_c;

  assign in_frame_c = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (~in_frame_c),
    .toggle_en_i (state_q == ST_SHIFT),
    .tick_o      (tick),
    .cnt_o       (cnt),
    .sclk_o      (sclk_w)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso_i;
  assign miso_s      = mosi_q;
`else
  assign miso_s = miso_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      byte_q     <= '0;
      hp_q       <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      wbuf_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_req_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      hp_q       <= hp_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      wbuf_q     <= wbuf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_req_q   <= wr_req_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    byte_d      = byte_q;
    hp_d        = hp_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    wbuf_d      = wbuf_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_req_d    = 1'b0;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    abyte_c     = fmt_addr_byte(rd_nwr_i, addr_i);
    len_clamp_c = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
    // Read slots repeat the address byte, the final slot sends 0x00
    if (rd_q)
      next_byte_c = ((byte_q + LEN_W'(1)) == len_q) ? 8'h00 : fmt_addr_byte(rd_q, addr_q);
    else
      next_byte_c = wbuf_q;
    pos_c = 32'(hp_q) * CLK_DIV + 32'(cnt);

    if (wr_req_q) wbuf_d = wr_data_i;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rd_d   = rd_nwr_i;
          addr_d = addr_i;
          len_d  = len_clamp_c;
          byte_d = '0;
          hp_d   = '0;
          busy_d = 1'b1;
          if (len_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            cs_n_d   = 1'b0;
            sh_d     = abyte_c;
            mosi_d   = abyte_c[7];
            wr_req_d = ~rd_nwr_i;
          end
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Request the following write byte two clocks ahead of this byte's last falling edge
        if (!rd_q && byte_q != '0 && byte_q < len_q && pos_c == WREQ_AT) wr_req_d = 1'b1;
        if (tick) begin
          hp_d = hp_q + 4'd1;
          if (!hp_q[0]) begin
            rx_d = {rx_q[6:0], miso_s};
            if (hp_q == 4'd14 && rd_q && byte_q != '0) begin
              rd_data_d  = {rx_q[6:0], miso_s};
              rd_valid_d = 1'b1;
            end
          end else if (hp_q != 4'd15) begin
            sh_d   = {sh_q[6:0], 1'b0};
            mosi_d = sh_q[6];
          end else if (byte_q == len_q) begin
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
          end else begin
            byte_d = byte_q + LEN_W'(1);
            sh_d   = next_byte_c;
            mosi_d = next_byte_c[7];
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_DONE;
          cs_n_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_req_o   = wr_req_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sclk_o     = sclk_w;
  assign cs_n_o     = cs_n_q;
  assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_mfrc522_spi_ctrl.sv
// Bench for mfrc522_spi_ctrl: SPI slave model, write-data feeder and
// transaction-level reference checks (directed plus $urandom transactions).
module tb_mfrc522_spi_ctrl;

  localparam int unsigned D    = 4;
  localparam int unsigned MAXL = 16;
  localparam int unsigned LW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_nwr;
  logic [5:0]    addr;
  logic [LW-1:0] len;
  logic          wr_req;
  logic [7:0]    wr_data = 8'h00;
  logic [7:0]    rd_data;
  logic          rd_valid, busy, done, sclk, cs_n, mosi;
  logic          miso = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wdat [0:31];
  logic [7:0] rsp  [0:31];
  logic [7:0] mosi_log [$];
  logic [7:0] rd_log   [$];
  int         wr_cnt   = 0;
  int         wr_base  = 0;
  int         cs_falls = 0;
  int         done_cnt = 0;
  int         sbit     = 0;
  int         mbits    = 0;
  logic [7:0] msh      = 8'h00;

  mfrc522_spi_ctrl #(.CLK_DIV(D), .MAX_LEN(MAXL), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .rd_nwr_i   (rd_nwr),
    .addr_i     (addr),
    .len_i      (len),
    .wr_req_o   (wr_req),
    .wr_data_i  (wr_data),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .busy_o     (busy),
    .done_o     (done),
    .sclk_o     (sclk),
    .cs_n_o     (cs_n),
    .mosi_o     (mosi),
    .miso_i     (miso)
  );

  always #5 clk = ~clk;

  // Slave returns 0x5A during the address slot, then rsp[] bytes
  function automatic logic miso_bit(input int idx);
    int         slot;
    logic [7:0] b;
    slot = idx / 8;
    b    = (slot == 0) ? 8'h5A : rsp[slot-1];
    return b[7 - (idx % 8)];
  endfunction

  function automatic logic [7:0] exp_rd(input bit rd, input logic [5:0] a, input int n, input int k);
`ifdef SPI_LOOPBACK_EN
    return (k == n - 1) ? 8'h00 : {rd, a, 1'b0};
`else
    return rsp[k];
`endif
  endfunction

  always @(negedge cs_n) begin
    cs_falls++;
    sbit  = 0;
    mbits = 0;
    miso  = miso_bit(0);
  end

  always @(negedge sclk) if (cs_n === 1'b0) begin
    sbit++;
    miso = miso_bit(sbit);
  end

  always @(posedge sclk) if (cs_n === 1'b0) begin
    msh = {msh[6:0], mosi};
    mbits++;
    if (mbits % 8 == 0) mosi_log.push_back(msh);
  end

  always @(posedge clk) begin
    #1;
    if (wr_req === 1'b1) begin
      wr_data = wdat[wr_cnt - wr_base];
      wr_cnt++;
    end
    if (rd_valid === 1'b1) rd_log.push_back(rd_data);
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input bit rd, input logic [5:0] a, input int l);
    int          n_eff, lat, cs0, mb, rb;
    bit          got;
    logic [7:0]  ab, e;
    logic [31:0] obs;
    n_eff   = (l > int'(MAXL)) ? int'(MAXL) : l;
    ab      = {rd, a, 1'b0};
    cs0     = cs_falls;
    mb      = mosi_log.size();
    rb      = rd_log.size();
    wr_base = wr_cnt;
    @(negedge clk);
    rd_nwr = rd; addr = a; len = LW'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (!rd || n_eff == 0)
      chk("latency", 32'(lat), (n_eff == 0) ? 32'd1 : 32'((2 + 16 * (n_eff + 1)) * D + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("cs_n_at_done", 32'(cs_n), 32'd1);
    chk("sclk_at_done", 32'(sclk), 32'd0);
    chk("cs_falls", 32'(cs_falls - cs0), (n_eff == 0) ? 32'd0 : 32'd1);
    chk("mosi_bytes", 32'(mosi_log.size() - mb), (n_eff == 0) ? 32'd0 : 32'(n_eff + 1));
    for (int i = 0; i < ((n_eff == 0) ? 0 : n_eff + 1); i++) begin
      if (rd) e = (i < n_eff) ? ab : 8'h00;
      else    e = (i == 0) ? ab : wdat[i-1];
      obs = (mb + i < mosi_log.size()) ? 32'(mosi_log[mb + i]) : 'x;
      chk("mosi_byte", obs, 32'(e));
    end
    chk("wr_req_count", 32'(wr_cnt - wr_base), rd ? 32'd0 : 32'(n_eff));
    chk("rd_valid_count", 32'(rd_log.size() - rb), rd ? 32'(n_eff) : 32'd0);
    if (rd) for (int k = 0; k < n_eff; k++) begin
      obs = (rb + k < rd_log.size()) ? 32'(rd_log[rb + k]) : 'x;
      chk("rd_data", obs, 32'(exp_rd(rd, a, n_eff, k)));
    end
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin : main
    int  d0, mb;
    bit  got;
    rst = 1'b1; start = 1'b0; rd_nwr = 1'b0; addr = '0; len = '0;
    for (int i = 0; i < 32; i++) begin wdat[i] = 8'h00; rsp[i] = 8'h00; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    wdat[0] = 8'h0F;
    run_txn(1'b0, 6'h01, 1);

    rsp[0] = 8'h92;
    run_txn(1'b1, 6'h37, 1);

    rsp[0] = 8'hA1; rsp[1] = 8'hB2; rsp[2] = 8'hC3;
    run_txn(1'b1, 6'h09, 3);

    run_txn(1'b0, 6'h12, 0);
    run_txn(1'b1, 6'h12, 0);

    for (int i = 0; i < 20; i++) wdat[i] = 8'($urandom);
    run_txn(1'b0, 6'h2C, 20);

    rsp[0] = 8'h3C; rsp[1] = 8'hC5;
    run_txn(1'b1, 6'h09, 2);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) begin wdat[i] = 8'($urandom); rsp[i] = 8'($urandom); end
      run_txn(1'($urandom), 6'($urandom), int'($urandom_range(0, 18)));
    end

    // Second start while busy is ignored, then reset abandons the frame
    for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
    d0      = done_cnt;
    mb      = mosi_log.size();
    wr_base = wr_cnt;
    @(negedge clk);
    rd_nwr = 1'b0; addr = 6'h05; len = LW'(4); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rd_nwr = 1'b1; addr = 6'h3A; len = LW'(2); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if (mosi_log.size() - mb >= 2) got = 1'b1;
    end
    chk("reached_byte2", 32'(got), 32'd1);
    chk("ignored_start_addr", (mb < mosi_log.size()) ? 32'(mosi_log[mb]) : 'x, 32'h0A);
    chk("ignored_start_data", (mb + 1 < mosi_log.size()) ? 32'(mosi_log[mb + 1]) : 'x, 32'(wdat[0]));
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_req", 32'(wr_req), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
